// File: rtl/window_fetcher.sv
// Raster-scans an image, issuing one 5x5-window read per position on the RAM enable/finish handshake,
// and hands each captured window to the convolution datapath over valid/ready. All outputs registered.
module window_fetcher #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [ADDR_W-1:0]      img_width,
  input  logic [ADDR_W-1:0]      img_height,
  input  logic                   stride_two,
  output logic                   mem_enable,
  output logic                   mem_write,
  output logic [ADDR_W-1:0]      mem_address,
  output logic [ADDR_W-1:0]      mem_offset,
  input  logic                   mem_finish,
  input  logic [25*DATA_W-1:0]   mem_data,
  output logic [25*DATA_W-1:0]   win_data,
  output logic                   win_valid,
  input  logic                   win_ready,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] FIVE   = ADDR_W'(5);
  localparam logic [ADDR_W:0]   FIVE_X = (ADDR_W+1)'(5);

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      width_q, width_d;
  logic [ADDR_W-1:0]      height_q, height_d;
  logic                   s2_q, s2_d;
  logic [ADDR_W-1:0]      x_q, x_d;
  logic [ADDR_W-1:0]      y_q, y_d;
  logic [ADDR_W-1:0]      row_q, row_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [25*DATA_W-1:0]   win_q, win_d;
  logic                   en_q, en_d;
  logic                   vld_q, vld_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [ADDR_W-1:0]      step;
  logic [ADDR_W-1:0]      row_step;
  logic [ADDR_W:0]        x_lim;
  logic [ADDR_W:0]        y_lim;
  logic                   last_col;
  logic                   last_row;

  // Limits only meaningful once a scan is running (both dims already >= 5).
  assign step     = s2_q ? ADDR_W'(2) : ADDR_W'(1);
  assign row_step = s2_q ? {width_q[ADDR_W-2:0], 1'b0} : width_q;
  assign x_lim    = {1'b0, width_q}  - FIVE_X;
  assign y_lim    = {1'b0, height_q} - FIVE_X;
  assign last_col = ({1'b0, x_q} + {1'b0, step}) > x_lim;
  assign last_row = ({1'b0, y_q} + {1'b0, step}) > y_lim;

  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    height_d = height_q;
    s2_d     = s2_q;
    x_d      = x_q;
    y_d      = y_q;
    row_d    = row_q;
    addr_d   = addr_q;
    win_d    = win_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          width_d  = img_width;
          height_d = img_height;
          s2_d     = stride_two;
          if (img_width < FIVE || img_height < FIVE) begin
            state_d = S_DONE;
          end else begin
            x_d     = '0;
            y_d     = '0;
            row_d   = base_addr;
            addr_d  = base_addr;
            state_d = S_ISSUE;
          end
        end
      end
      // mem_finish may still show the previous completion here, so it is not looked at.
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (mem_finish) begin
          win_d   = mem_data;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (vld_q && win_ready) begin
          if (last_col) begin
            if (last_row) begin
              state_d = S_DONE;
            end else begin
              x_d     = '0;
              y_d     = y_q + step;
              row_d   = row_q + row_step;
              addr_d  = row_q + row_step;
              state_d = S_ISSUE;
            end
          end else begin
            x_d     = x_q + step;
            addr_d  = addr_q + step;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    en_d   = (state_d == S_ISSUE) || (state_d == S_WAIT);
    vld_d  = (state_d == S_HOLD);
    busy_d = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_HOLD);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      width_q  <= '0;
      height_q <= '0;
      s2_q     <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      row_q    <= '0;
      addr_q   <= '0;
      win_q    <= '0;
      en_q     <= 1'b0;
      vld_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      width_q  <= width_d;
      height_q <= height_d;
      s2_q     <= s2_d;
      x_q      <= x_d;
      y_q      <= y_d;
      row_q    <= row_d;
      addr_q   <= addr_d;
      win_q    <= win_d;
      en_q     <= en_d;
      vld_q    <= vld_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign mem_enable  = en_q;
  assign mem_write   = 1'b0;
  assign mem_address = addr_q;
  assign mem_offset  = width_q;
  assign win_data    = win_q;
  assign win_valid   = vld_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_window_fetcher.sv
// Bench for window_fetcher: behavioural RAM responder plus a list-of-positions reference model.
module tb_window_fetcher;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int WB = 25 * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr, img_width, img_height;
  logic          stride_two;
  logic          mem_enable, mem_write;
  logic [AW-1:0] mem_address, mem_offset;
  logic          mem_finish;
  logic [WB-1:0] mem_data, win_data;
  logic          win_valid, win_ready, busy, done;

  int n_cmp = 0;
  int n_bad = 0;
  int ram_delay = 0;
  int last_delay = 0;
  int ram_cnt = 0;
  bit ram_active = 1'b0;
  bit ram_en_prev = 1'b0;

  window_fetcher #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .img_width(img_width), .img_height(img_height), .stride_two(stride_two),
    .mem_enable(mem_enable), .mem_write(mem_write), .mem_address(mem_address),
    .mem_offset(mem_offset), .mem_finish(mem_finish), .mem_data(mem_data),
    .win_data(win_data), .win_valid(win_valid), .win_ready(win_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pix(input logic [15:0] a);
    logic [15:0] m;
    m = a * 16'd40503;
    return m ^ 16'h5A5A;
  endfunction

  function automatic logic [WB-1:0] exp_window(input logic [15:0] a, input logic [15:0] w);
    logic [WB-1:0] v;
    logic [15:0]   p;
    v = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        p = a + 16'(r) * w + 16'(c);
        v[(r*5+c)*DW +: DW] = pix(p);
      end
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RAM: clears finish on a new enable, completes (2+delay) cycles after the request rose.
  always @(negedge clk) begin
    if (rst) begin
      mem_finish  = 1'b0;
      ram_active  = 1'b0;
      ram_en_prev = 1'b0;
    end else begin
      if (mem_enable && !ram_en_prev) begin
        mem_finish = 1'b0;
        ram_cnt    = (ram_delay < 0) ? int'($urandom_range(0, 3)) : ram_delay;
        last_delay = ram_cnt;
        ram_active = 1'b1;
      end else if (ram_active) begin
        if (ram_cnt == 0) begin
          mem_finish = 1'b1;
          mem_data   = exp_window(mem_address, mem_offset);
          ram_active = 1'b0;
        end else begin
          ram_cnt--;
        end
      end
      ram_en_prev = mem_enable;
    end
  end

  task automatic run_scan(input logic [15:0] base, input logic [15:0] W, input logic [15:0] H,
                          input logic s2, input int dly, input int pct, input int stall_n,
                          input bit poke);
    logic [15:0]   exp_addr[$];
    logic [63:0]   a;
    logic [WB-1:0] held;
    int S, n, cyc, req_idx, xfer_idx, en_run, valid_age;
    bit en_prev, pend_xfer, finished, stall_prev, seen_valid;
    S = s2 ? 2 : 1;
    if (W >= 5 && H >= 5) begin
      for (int y = 0; y <= int'(H) - 5; y += S) begin
        for (int x = 0; x <= int'(W) - 5; x += S) begin
          a = 64'(base) + 64'(y) * 64'(W) + 64'(x);
          exp_addr.push_back(a[15:0]);
        end
      end
    end
    n = exp_addr.size();
    req_idx = 0; xfer_idx = 0; en_run = 0; valid_age = 0;
    en_prev = 0; pend_xfer = 0; finished = 0; stall_prev = 0; seen_valid = 0;
    held = '0;
    ram_delay = dly;

    @(negedge clk);
    base_addr = base; img_width = W; img_height = H; stride_two = s2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!finished && cyc < 3000) begin
      if (pend_xfer) begin
        if (xfer_idx < n) chk("next_req_en", mem_enable, 1'b1);
        else chk("done_after_last", done, 1'b1);
        pend_xfer = 0;
      end
      if (n == 0 && cyc == 1) chk("degen_done", done, 1'b1);
      if (mem_enable && !en_prev) begin
        chk("req_in_range", req_idx < n, 1'b1);
        if (req_idx < n) chk("req_addr", mem_address, exp_addr[req_idx]);
        chk("req_offset", mem_offset, W);
        chk("mem_write", mem_write, 1'b0);
        req_idx++;
      end
      if (!mem_enable && en_prev) chk("en_len", en_run, 2 + last_delay);
      en_run  = mem_enable ? en_run + 1 : 0;
      en_prev = mem_enable;
      if (done) begin
        chk("busy_at_done", busy, 1'b0);
        finished = 1;
      end else if (n > 0) begin
        chk("busy", busy, 1'b1);
      end
      if (win_valid) begin
        chk("en_low_hold", mem_enable, 1'b0);
        if (!seen_valid) begin
          chk("first_latency", cyc, 3 + last_delay);
          seen_valid = 1;
        end
        if (stall_prev) chk("stall_data", win_data, held);
        win_ready = (valid_age >= stall_n) && ($urandom_range(0, 99) < pct);
        valid_age++;
        if (win_ready) begin
          chk("win_data", win_data, (xfer_idx < n) ? exp_window(exp_addr[xfer_idx], W) : '0);
          xfer_idx++;
          pend_xfer = 1; stall_prev = 0; valid_age = 0;
        end else begin
          stall_prev = 1;
          held = win_data;
        end
      end else begin
        if (stall_prev) chk("stall_valid", win_valid, 1'b1);
        stall_prev = 0;
        win_ready = ($urandom_range(0, 99) < pct);
      end
      if (poke && cyc == 4) begin
        start = 1'b1; base_addr = ~base; img_width = W + 16'd3;
      end else if (poke && cyc == 5) begin
        start = 1'b0; base_addr = base; img_width = W;
      end
      if (!finished) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("scan_finished", finished, 1'b1);
    chk("win_count", xfer_idx, n);
    chk("req_count", req_idx, n);
    start = 1'b0;
    win_ready = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
    chk("busy_after", busy, 1'b0);
    chk("idle_en", mem_enable, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; img_width = '0; img_height = '0;
    stride_two = 1'b0; win_ready = 1'b0; mem_finish = 1'b0; mem_data = '0;
    #3;
    chk("rst_en", mem_enable, 1'b0);
    chk("rst_valid", win_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_addr", mem_address, 16'h0);
    chk("rst_offset", mem_offset, 16'h0);
    chk("rst_data", win_data, '0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;

    run_scan(16'd100, 16'd5, 16'd5, 1'b0, 0, 100, 0, 1'b0);
    run_scan(16'd0,   16'd7, 16'd6, 1'b0, 0, 100, 0, 1'b0);
    run_scan(16'd0,   16'd9, 16'd9, 1'b1, 0, 100, 0, 1'b1);
    run_scan(16'd50,  16'd6, 16'd5, 1'b0, 2, 100, 4, 1'b0);
    run_scan(16'd7,   16'd4, 16'd10, 1'b0, 0, 100, 0, 1'b1);

    @(negedge clk);
    base_addr = 16'd300; img_width = 16'd7; img_height = 16'd6; stride_two = 1'b0;
    ram_delay = 6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_en", mem_enable, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_en", mem_enable, 1'b0);
    chk("mid_rst_valid", win_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_addr", mem_address, 16'h0);
    chk("mid_rst_offset", mem_offset, 16'h0);
    chk("mid_rst_data", win_data, '0);
    @(negedge clk);
    #2 rst = 1'b0;
    run_scan(16'd200, 16'd5, 16'd5, 1'b0, 0, 100, 0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      run_scan(16'($urandom), 16'(5 + $urandom_range(0, 7)), 16'(5 + $urandom_range(0, 5)),
               1'($urandom_range(0, 1)), -1, 60, int'($urandom_range(0, 2)),
               bit'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
